rb1_arbiter: RTL and testbench

//  Shares the single-port RB1 register bank between two requesters:

---
 rtl/rb1_arbiter.sv | 149 ++++++++++++++
 tb/tb_rb1_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rb1_arbiter.sv
// Round-robin arbiter sharing the single-port RB1 register bank between the host
// port (0) and the S1 streaming reader (1), with per-port burst lock.
module rb1_arbiter #(
    parameter int DEPTH = 18,
    parameter int AW    = 5,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          lock0,
    input  logic          lock1,
    input  logic          rw0,
    input  logic          rw1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          err0,
    output logic          err1,
    output logic          RB1_RW,
    output logic [AW-1:0] RB1_A,
    output logic [DW-1:0] RB1_D,
    input  logic [DW-1:0] RB1_Q
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_t state;
    state_t state_nx;
    logic   rr_last;
    logic   rd_pend0, rd_pend1;
    logic   oor_pend0, oor_pend1;
    logic   in0, in1;
    logic   issue0, issue1;

    assign in0    = ({1'b0, addr0} < DEPTH_W);
    assign in1    = ({1'b0, addr1} < DEPTH_W);
    // Entering or staying in OWNi always implies req_i is high.
    assign issue0 = (state_nx == OWN0);
    assign issue1 = (state_nx == OWN1);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (req0 && req1)
                    state_nx = rr_last ? OWN0 : OWN1;
                else if (req0)
                    state_nx = OWN0;
                else if (req1)
                    state_nx = OWN1;
                else
                    state_nx = IDLE;
            end
            OWN0: begin
                if (req0)
                    state_nx = (!lock0 && req1) ? OWN1 : OWN0;
                else
                    state_nx = req1 ? OWN1 : IDLE;
            end
            OWN1: begin
                if (req1)
                    state_nx = (!lock1 && req0) ? OWN0 : OWN1;
                else
                    state_nx = req0 ? OWN0 : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rr_last   <= 1'b1;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;
            rd_pend0  <= 1'b0;
            rd_pend1  <= 1'b0;
            oor_pend0 <= 1'b0;
            oor_pend1 <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            RB1_RW    <= 1'b1;
            RB1_A     <= '0;
            RB1_D     <= '0;
        end else begin
            state <= state_nx;
            if (issue0)
                rr_last <= 1'b0;
            else if (issue1)
                rr_last <= 1'b1;

            gnt0      <= issue0;
            gnt1      <= issue1;
            err0      <= issue0 && !in0;
            err1      <= issue1 && !in1;
            rd_pend0  <= issue0 && in0 && rw0;
            rd_pend1  <= issue1 && in1 && rw1;
            oor_pend0 <= issue0 && !in0;
            oor_pend1 <= issue1 && !in1;

            // Out-of-range accesses park the bus on a harmless read of address 0.
            RB1_RW <= 1'b1;
            if (issue0) begin
                if (in0) begin
                    RB1_A  <= addr0;
                    RB1_RW <= rw0;
                    RB1_D  <= wdata0;
                end else begin
                    RB1_A  <= '0;
                end
            end else if (issue1) begin
                if (in1) begin
                    RB1_A  <= addr1;
                    RB1_RW <= rw1;
                    RB1_D  <= wdata1;
                end else begin
                    RB1_A  <= '0;
                end
            end

            rvalid0 <= rd_pend0 || oor_pend0;
            rvalid1 <= rd_pend1 || oor_pend1;
            if (oor_pend0)
                rdata0 <= '0;
            else if (rd_pend0)
                rdata0 <= RB1_Q;
            if (oor_pend1)
                rdata1 <= '0;
            else if (rd_pend1)
                rdata1 <= RB1_Q;
        end
    end

endmodule

// File: tb/tb_rb1_arbiter.sv
// Self-checking bench for rb1_arbiter: table-driven tie/write/out-of-range vectors,
// hand-written burst, lock and reset sequences, and a read-data scoreboard.
module tb_rb1_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, lock0, lock1, rw0, rw1;
    logic [4:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [7:0] rdata0, rdata1;
    logic       rb1_rw;
    logic [4:0] rb1_a;
    logic [7:0] rb1_d;
    logic [7:0] rb1_q;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp0[$];
    logic [7:0] exp1[$];

    typedef struct {
        logic       r0;
        logic       rw0;
        logic [4:0] a0;
        logic [7:0] d0;
        logic       r1;
        logic [4:0] a1;
        logic [7:0] q;
        logic       g0;
        logic       g1;
        logic       e0;
        logic       v0;
        logic       v1;
        logic       rw;
    } vec_t;

    vec_t tbl [13];

    always #5 clk = ~clk;

    rb1_arbiter #(.DEPTH(18), .AW(5), .DW(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .rw0(rw0), .rw1(rw1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
        .RB1_RW(rb1_rw), .RB1_A(rb1_a), .RB1_D(rb1_d), .RB1_Q(rb1_q)
    );

    // RB1 bank model: address registered by the arbiter, data seen the following cycle.
    logic [7:0] mem [0:31];
    logic       loaded = 1'b0;
    assign rb1_q = mem[rb1_a];

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 32; i++) mem[i] <= 8'h10 + 8'(i);
            loaded <= 1'b1;
        end else if (!rb1_rw) begin
            mem[rb1_a] <= rb1_d;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(logic r0, logic w0, logic [4:0] a0, logic [7:0] d0, logic r1,
                                logic [4:0] a1, logic [7:0] q, logic g0, logic g1, logic e0,
                                logic v0, logic v1, logic rw);
        vec_t v;
        v.r0 = r0; v.rw0 = w0; v.a0 = a0; v.d0 = d0; v.r1 = r1; v.a1 = a1; v.q = q;
        v.g0 = g0; v.g1 = g1; v.e0 = e0; v.v0 = v0; v.v1 = v1; v.rw = rw;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        req0 = v.r0; rw0 = v.rw0; addr0 = v.a0; wdata0 = v.d0; lock0 = 1'b0;
        req1 = v.r1; rw1 = 1'b1; addr1 = v.a1; wdata1 = 8'h00; lock1 = 1'b0;
        if (v.g0 && (v.rw0 || v.a0 >= 5'd18)) exp0.push_back(v.q);
        if (v.g1) exp1.push_back(v.q);
    endtask

    function automatic logic [7:0] shadow(input int n);
        return (n == 5) ? 8'hA5 : 8'h10 + 8'(n);
    endfunction

    // Scoreboard: every rvalid pops the oldest expected read data for that port.
    always @(posedge clk) begin
        #1;
        if (rvalid0) begin
            if (exp0.size() == 0) checkOutput("rvalid0_unexpected", 32'd1, 32'd0);
            else checkOutput("rdata0", rdata0, exp0.pop_front());
        end
        if (rvalid1) begin
            if (exp1.size() == 0) checkOutput("rvalid1_unexpected", 32'd1, 32'd0);
            else checkOutput("rdata1", rdata1, exp1.pop_front());
        end
        checkOutput("gnt_exclusive", 32'(gnt0 & gnt1), 32'd0);
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tbl[0]  = mk(1,1,0,8'h00, 1,4, 8'h10, 1,0,0,0,0,1);
        tbl[1]  = mk(1,1,1,8'h00, 1,4, 8'h14, 0,1,0,1,0,1);
        tbl[2]  = mk(1,1,1,8'h00, 1,5, 8'h11, 1,0,0,0,1,1);
        tbl[3]  = mk(1,1,2,8'h00, 1,5, 8'h15, 0,1,0,1,0,1);
        tbl[4]  = mk(1,1,2,8'h00, 1,6, 8'h12, 1,0,0,0,1,1);
        tbl[5]  = mk(1,1,3,8'h00, 1,6, 8'h16, 0,1,0,1,0,1);
        tbl[6]  = mk(1,1,3,8'h00, 1,7, 8'h13, 1,0,0,0,1,1);
        tbl[7]  = mk(0,1,0,8'h00, 1,7, 8'h17, 0,1,0,1,0,1);
        tbl[8]  = mk(0,1,0,8'h00, 0,0, 8'h00, 0,0,0,0,1,1);
        tbl[9]  = mk(1,0,5,8'hA5, 0,0, 8'h00, 1,0,0,0,0,0);
        tbl[10] = mk(1,1,5,8'h00, 0,0, 8'hA5, 1,0,0,0,0,1);
        tbl[11] = mk(1,0,20,8'h5A, 0,0, 8'h00, 1,0,1,1,0,1);
        tbl[12] = mk(0,1,0,8'h00, 0,0, 8'h00, 0,0,0,1,0,1);

        rst = 1'b0;
        req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; rw0 = 1; rw1 = 1;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_rb1_rw", 32'(rb1_rw), 32'd1);
        checkOutput("reset_rb1_a", 32'(rb1_a), 32'd0);
        checkOutput("reset_rb1_d", 32'(rb1_d), 32'd0);
        checkOutput("reset_gnt", 32'({gnt0, gnt1, rvalid0, rvalid1, err0, err1}), 32'd0);
        checkOutput("reset_rdata", 32'({rdata0, rdata1}), 32'd0);
        rst = 1'b1;
        tick();

        // Port-1 streaming burst over the whole bank.
        for (int n = 0; n < 18; n++) begin
            req1 = 1'b1; rw1 = 1'b1; addr1 = 5'(n);
            exp1.push_back(8'h10 + 8'(n));
            tick();
            checkOutput($sformatf("burst_gnt1_%0d", n), 32'(gnt1), 32'd1);
            checkOutput($sformatf("burst_gnt0_%0d", n), 32'(gnt0), 32'd0);
            checkOutput($sformatf("burst_a_%0d", n), 32'(rb1_a), 32'(n));
            checkOutput($sformatf("burst_rvalid1_%0d", n), 32'(rvalid1), 32'(n > 0));
        end
        req1 = 1'b0;
        tick();
        checkOutput("burst_end_gnt1", 32'(gnt1), 32'd0);
        checkOutput("burst_end_rw", 32'(rb1_rw), 32'd1);
        tick();

        // Tie, write-then-read and out-of-range vectors.
        for (int i = 0; i < 13; i++) begin
            applyStimulus(tbl[i]);
            tick();
            checkOutput($sformatf("vec%0d_gnt0", i), 32'(gnt0), 32'(tbl[i].g0));
            checkOutput($sformatf("vec%0d_gnt1", i), 32'(gnt1), 32'(tbl[i].g1));
            checkOutput($sformatf("vec%0d_err0", i), 32'(err0), 32'(tbl[i].e0));
            checkOutput($sformatf("vec%0d_rvalid0", i), 32'(rvalid0), 32'(tbl[i].v0));
            checkOutput($sformatf("vec%0d_rvalid1", i), 32'(rvalid1), 32'(tbl[i].v1));
            checkOutput($sformatf("vec%0d_rb1_rw", i), 32'(rb1_rw), 32'(tbl[i].rw));
        end
        checkOutput("mem5_written", 32'(mem[5]), 32'h A5);
        checkOutput("mem20_untouched", 32'(mem[20]), 32'h24);
        checkOutput("mem0_untouched", 32'(mem[0]), 32'h10);

        // Locked port-1 burst while port 0 waits.
        req0 = 1'b1; rw0 = 1'b1; addr0 = 5'd3;
        exp0.push_back(8'h13);
        for (int n = 0; n < 18; n++) begin
            req1 = 1'b1; lock1 = 1'b1; rw1 = 1'b1; addr1 = 5'(n);
            exp1.push_back(shadow(n));
            tick();
            checkOutput($sformatf("lock_gnt1_%0d", n), 32'(gnt1), 32'd1);
            checkOutput($sformatf("lock_gnt0_%0d", n), 32'(gnt0), 32'd0);
        end
        req1 = 1'b0; lock1 = 1'b0;
        tick();
        checkOutput("lock_release_gnt0", 32'(gnt0), 32'd1);
        checkOutput("lock_release_gnt1", 32'(gnt1), 32'd0);
        req0 = 1'b0;
        tick();
        checkOutput("lock_done_gnt0", 32'(gnt0), 32'd0);
        tick();

        // Reset in the middle of a port-1 burst, after the 7th read.
        for (int n = 0; n < 7; n++) begin
            req1 = 1'b1; rw1 = 1'b1; addr1 = 5'(n);
            exp1.push_back(shadow(n));
            tick();
            checkOutput($sformatf("rst_burst_gnt1_%0d", n), 32'(gnt1), 32'd1);
        end
        #1;
        exp1.delete();
        rst = 1'b0;
        req1 = 1'b0;
        #1;
        checkOutput("midrst_gnt", 32'({gnt0, gnt1}), 32'd0);
        checkOutput("midrst_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
        checkOutput("midrst_err", 32'({err0, err1}), 32'd0);
        checkOutput("midrst_rdata1", 32'(rdata1), 32'd0);
        checkOutput("midrst_rb1_rw", 32'(rb1_rw), 32'd1);
        checkOutput("midrst_rb1_a", 32'(rb1_a), 32'd0);
        checkOutput("midrst_rb1_d", 32'(rb1_d), 32'd0);
        tick();
        checkOutput("midrst_no_rvalid1", 32'(rvalid1), 32'd0);
        checkOutput("midrst_no_write", 32'(mem[6]), 32'h16);
        rst = 1'b1;
        req0 = 1'b1; rw0 = 1'b1; addr0 = 5'd1;
        req1 = 1'b1; rw1 = 1'b1; addr1 = 5'd2;
        exp0.push_back(8'h11);
        tick();
        checkOutput("post_rst_tie_gnt0", 32'(gnt0), 32'd1);
        checkOutput("post_rst_tie_gnt1", 32'(gnt1), 32'd0);
        req0 = 1'b0;
        exp1.push_back(8'h12);
        tick();
        checkOutput("post_rst_gnt1", 32'(gnt1), 32'd1);
        req1 = 1'b0;
        repeat (3) tick();
        checkOutput("exp0_drained", 32'(exp0.size()), 32'd0);
        checkOutput("exp1_drained", 32'(exp1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
